// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode/execute pipeline register.
// Control-bundle bit positions and the default packed payload layout.
package pipe_pkg;

    localparam int CTRL_WIDTH_DEFAULT = 9;

    localparam int CTRL_REG_WRITE     = 8;
    localparam int CTRL_RESULT_SRC_HI = 7;
    localparam int CTRL_RESULT_SRC_LO = 6;
    localparam int CTRL_MEM_WRITE     = 5;
    localparam int CTRL_JUMP          = 4;
    localparam int CTRL_BRANCH        = 3;
    localparam int CTRL_ALU_CTRL_HI   = 2;
    localparam int CTRL_ALU_CTRL_LO   = 1;
    localparam int CTRL_ALU_SRC       = 0;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm_ext;
        logic [31:0] pc_plus4;
        logic [CTRL_WIDTH_DEFAULT-1:0] ctrl;
    } de_payload_t;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: a valid bit plus a payload register.
// Reset and flush both empty the slot and zero the payload.
module pipe_entry #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (load_i) begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/de_pipe_reg.sv
// Decode-to-execute register with valid/ready, stall, flush and
// an optional skid entry that registers the ready path to decode.
module de_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int CTRL_WIDTH    = CTRL_WIDTH_DEFAULT,
    parameter bit SKID_EN       = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     validD_i,
    output logic                     readyD_o,
    input  logic [DATA_WIDTH-1:0]    rd1D_i,
    input  logic [DATA_WIDTH-1:0]    rd2D_i,
    input  logic [DATA_WIDTH-1:0]    imm_extD_i,
    input  logic [ADDRESS_WIDTH-1:0] pcD_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4D_i,
    input  logic [4:0]               rdD_i,
    input  logic [CTRL_WIDTH-1:0]    ctrlD_i,
    output logic                     validE_o,
    input  logic                     readyE_i,
    output logic [DATA_WIDTH-1:0]    rd1E_o,
    output logic [DATA_WIDTH-1:0]    rd2E_o,
    output logic [DATA_WIDTH-1:0]    imm_extE_o,
    output logic [ADDRESS_WIDTH-1:0] pcE_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4E_o,
    output logic [4:0]               rdE_o,
    output logic [CTRL_WIDTH-1:0]    ctrlE_o,
    output logic [1:0]               countE_o
);

    localparam int W = 3 * DATA_WIDTH + 2 * ADDRESS_WIDTH + 5 + CTRL_WIDTH;

    logic [W-1:0] in_data;
    logic [W-1:0] main_data;
    logic [W-1:0] main_din;
    logic [W-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] ctrl_q;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;
    logic main_load;
    logic main_vin;

    assign in_data = {rd1D_i, rd2D_i, pcD_i, rdD_i,
                      imm_extD_i, pc_plus4D_i, ctrlD_i};

    assign in_fire   = validD_i & readyD_o;
    assign out_fire  = main_valid & readyE_i;
    assign main_load = ~main_valid | out_fire;

    // Skid contents always drain ahead of newer input.
    assign main_vin = skid_valid | in_fire;
    assign main_din = skid_valid ? skid_data : in_data;

    pipe_entry #(.W(W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .load_i  (main_load),
        .valid_i (main_vin),
        .data_i  (main_din),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic skid_load;

            assign skid_load = (main_load & skid_valid)
                             | (in_fire & main_valid & ~out_fire);

            pipe_entry #(.W(W)) u_skid (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clr_i   (clr_i),
                .load_i  (skid_load),
                .valid_i (in_fire),
                .data_i  (in_data),
                .valid_o (skid_valid),
                .data_o  (skid_data)
            );

            assign readyD_o = ~skid_valid;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign readyD_o   = ~main_valid | readyE_i;
        end
    endgenerate

    assign {rd1E_o, rd2E_o, pcE_o, rdE_o,
            imm_extE_o, pc_plus4E_o, ctrl_q} = main_data;

    // A bubble must never carry live control.
    assign ctrlE_o  = main_valid ? ctrl_q : '0;
    assign validE_o = main_valid;
    assign countE_o = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_de_pipe_reg.sv
// Bench for de_pipe_reg: skid and non-skid instances checked
// against FIFO scoreboards plus directed scenario checks.
module tb_de_pipe_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic clr = 1'b0, valid = 1'b0, ready_e = 1'b0;
    logic clr0 = 1'b0, valid0 = 1'b0, ready_e0 = 1'b0;
    logic [31:0] rd1 = '0, rd2 = '0, imm = '0, pc = '0, pc4 = '0;
    logic [4:0] rd = '0;
    logic [8:0] ctrl = '0;

    logic ready_d, valid_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
    logic [4:0] rd_e;
    logic [8:0] ctrl_e;
    logic [1:0] count_e;

    logic ready_d0, valid_e0;
    logic [31:0] rd1_e0, rd2_e0, imm_e0, pc_e0, pc4_e0;
    logic [4:0] rd_e0;
    logic [8:0] ctrl_e0;
    logic [1:0] count_e0;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    de_payload_t q[$];
    de_payload_t q0[$];
    de_payload_t in_pl, out_pl, out_pl0;

    assign in_pl   = {rd1, rd2, pc, rd, imm, pc4, ctrl};
    assign out_pl  = {rd1_e, rd2_e, pc_e, rd_e, imm_e, pc4_e, ctrl_e};
    assign out_pl0 = {rd1_e0, rd2_e0, pc_e0, rd_e0, imm_e0, pc4_e0, ctrl_e0};

    de_pipe_reg #(.SKID_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .validD_i(valid), .readyD_o(ready_d),
        .rd1D_i(rd1), .rd2D_i(rd2), .imm_extD_i(imm),
        .pcD_i(pc), .pc_plus4D_i(pc4), .rdD_i(rd), .ctrlD_i(ctrl),
        .validE_o(valid_e), .readyE_i(ready_e),
        .rd1E_o(rd1_e), .rd2E_o(rd2_e), .imm_extE_o(imm_e),
        .pcE_o(pc_e), .pc_plus4E_o(pc4_e), .rdE_o(rd_e),
        .ctrlE_o(ctrl_e), .countE_o(count_e)
    );

    de_pipe_reg #(.SKID_EN(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .clr_i(clr0),
        .validD_i(valid0), .readyD_o(ready_d0),
        .rd1D_i(rd1), .rd2D_i(rd2), .imm_extD_i(imm),
        .pcD_i(pc), .pc_plus4D_i(pc4), .rdD_i(rd), .ctrlD_i(ctrl),
        .validE_o(valid_e0), .readyE_i(ready_e0),
        .rd1E_o(rd1_e0), .rd2E_o(rd2_e0), .imm_extE_o(imm_e0),
        .pcE_o(pc_e0), .pc_plus4E_o(pc4_e0), .rdE_o(rd_e0),
        .ctrlE_o(ctrl_e0), .countE_o(count_e0)
    );

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (valid_e !== (q.size() > 0) || int'(count_e) != q.size()
                || ready_d !== (q.size() < 2)) begin
                errors++;
                $display("FAIL sb_state skid got v=%0b c=%0d r=%0b want size=%0d",
                         valid_e, count_e, ready_d, q.size());
            end
            if (valid_e === 1'b1 && q.size() > 0) begin
                checks++;
                if (out_pl !== q[0]) begin
                    errors++;
                    $display("FAIL sb_data skid got %h want %h", out_pl, q[0]);
                end
            end
            if (valid_e !== 1'b1) begin
                checks++;
                if (ctrl_e !== '0) begin
                    errors++;
                    $display("FAIL bubble_ctrl skid got %h want 0", ctrl_e);
                end
            end
            checks++;
            if (valid_e0 !== (q0.size() > 0) || int'(count_e0) != q0.size()
                || ready_d0 !== (q0.size() == 0 || ready_e0)) begin
                errors++;
                $display("FAIL sb_state noskid got v=%0b c=%0d r=%0b want size=%0d",
                         valid_e0, count_e0, ready_d0, q0.size());
            end
            if (valid_e0 === 1'b1 && q0.size() > 0) begin
                checks++;
                if (out_pl0 !== q0[0]) begin
                    errors++;
                    $display("FAIL sb_data noskid got %h want %h", out_pl0, q0[0]);
                end
            end
            if (valid_e0 !== 1'b1) begin
                checks++;
                if (ctrl_e0 !== '0) begin
                    errors++;
                    $display("FAIL bubble_ctrl noskid got %h want 0", ctrl_e0);
                end
            end
            if (rst) begin
                q.delete();
                q0.delete();
            end else begin
                if (valid_e && ready_e && q.size() > 0) void'(q.pop_front());
                if (clr) q.delete();
                else if (valid && ready_d) q.push_back(in_pl);
                if (valid_e0 && ready_e0 && q0.size() > 0) void'(q0.pop_front());
                if (clr0) q0.delete();
                else if (valid0 && ready_d0) q0.push_back(in_pl);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (valid_e !== 1'b0 || ready_d !== 1'b1 || count_e !== 2'd0
            || out_pl !== '0) begin
            errors++;
            $display("FAIL reset_skid got v=%0b r=%0b c=%0d pl=%h want 0/1/0/0",
                     valid_e, ready_d, count_e, out_pl);
        end
        checks++;
        if (valid_e0 !== 1'b0 || ready_d0 !== 1'b1 || count_e0 !== 2'd0
            || out_pl0 !== '0) begin
            errors++;
            $display("FAIL reset_noskid got v=%0b r=%0b c=%0d pl=%h want 0/1/0/0",
                     valid_e0, ready_d0, count_e0, out_pl0);
        end
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        rd1 = 32'h11; pc = 32'h100; ctrl = 9'h1FF;
        valid = 1'b1; ready_e = 1'b1;
        valid0 = 1'b1; ready_e0 = 1'b1;
        tick();
        valid = 1'b0; valid0 = 1'b0;
        checks++;
        if (valid_e !== 1'b1 || rd1_e !== 32'h11 || pc_e !== 32'h100
            || ctrl_e !== 9'h1FF) begin
            errors++;
            $display("FAIL basic_skid got v=%0b rd1=%h pc=%h ctrl=%h want 1/11/100/1ff",
                     valid_e, rd1_e, pc_e, ctrl_e);
        end
        checks++;
        if (valid_e0 !== 1'b1 || rd1_e0 !== 32'h11 || pc_e0 !== 32'h100
            || ctrl_e0 !== 9'h1FF) begin
            errors++;
            $display("FAIL basic_noskid got v=%0b rd1=%h pc=%h ctrl=%h want 1/11/100/1ff",
                     valid_e0, rd1_e0, pc_e0, ctrl_e0);
        end
        tick();
        checks++;
        if (valid_e !== 1'b0 || valid_e0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain got v=%0b v0=%0b want 0/0", valid_e, valid_e0);
        end
        ready_e = 1'b0; ready_e0 = 1'b0;
    endtask

    task automatic test_skid();
        ready_e = 1'b0;
        valid = 1'b1; rd1 = 32'hA; pc = 32'hA0; ctrl = 9'h0A1;
        tick();
        rd1 = 32'hB; pc = 32'hB0; ctrl = 9'h0B2;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (count_e !== 2'd2 || ready_d !== 1'b0 || rd1_e !== 32'hA
                || valid_e !== 1'b1) begin
                errors++;
                $display("FAIL skid_full got c=%0d r=%0b rd1=%h v=%0b want 2/0/a/1",
                         count_e, ready_d, rd1_e, valid_e);
            end
            tick();
        end
        ready_e = 1'b1;
        checks++;
        if (count_e !== 2'd2 || rd1_e !== 32'hA) begin
            errors++;
            $display("FAIL skid_hold got c=%0d rd1=%h want 2/a", count_e, rd1_e);
        end
        tick();
        checks++;
        if (valid_e !== 1'b1 || rd1_e !== 32'hB || count_e !== 2'd1
            || ready_d !== 1'b1) begin
            errors++;
            $display("FAIL skid_second got v=%0b rd1=%h c=%0d r=%0b want 1/b/1/1",
                     valid_e, rd1_e, count_e, ready_d);
        end
        tick();
        checks++;
        if (valid_e !== 1'b0 || count_e !== 2'd0) begin
            errors++;
            $display("FAIL skid_empty got v=%0b c=%0d want 0/0", valid_e, count_e);
        end
        ready_e = 1'b0;
    endtask

    task automatic test_flush();
        ready_e = 1'b0;
        valid = 1'b1; rd1 = 32'hA; pc = 32'hA0; ctrl = 9'h0A1;
        imm = 32'h5; pc4 = 32'hA4; rd2 = 32'h7; rd = 5'd3;
        tick();
        rd1 = 32'hC; pc = 32'hC0; ctrl = 9'h1FF;
        clr = 1'b1;
        tick();
        clr = 1'b0; valid = 1'b0;
        checks++;
        if (valid_e !== 1'b0 || ctrl_e !== '0 || out_pl !== '0
            || count_e !== 2'd0 || ready_d !== 1'b1) begin
            errors++;
            $display("FAIL flush got v=%0b ctrl=%h pl=%h c=%0d r=%0b want 0/0/0/0/1",
                     valid_e, ctrl_e, out_pl, count_e, ready_d);
        end
        ready_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid_e !== 1'b0) begin
                errors++;
                $display("FAIL flush_drop got v=%0b rd1=%h want 0", valid_e, rd1_e);
            end
        end
        ready_e = 1'b0;
    endtask

    task automatic test_noskid();
        ready_e0 = 1'b0;
        valid0 = 1'b1; rd1 = 32'hA; pc = 32'hA0; ctrl = 9'h0A1;
        tick();
        rd1 = 32'hB; pc = 32'hB0; ctrl = 9'h0B2;
        #1;
        checks++;
        if (ready_d0 !== 1'b0) begin
            errors++;
            $display("FAIL noskid_stall got r=%0b want 0", ready_d0);
        end
        ready_e0 = 1'b1;
        #1;
        checks++;
        if (ready_d0 !== 1'b1) begin
            errors++;
            $display("FAIL noskid_comb_ready got r=%0b want 1", ready_d0);
        end
        tick();
        valid0 = 1'b0;
        checks++;
        if (valid_e0 !== 1'b1 || rd1_e0 !== 32'hB || pc_e0 !== 32'hB0) begin
            errors++;
            $display("FAIL noskid_handoff got v=%0b rd1=%h pc=%h want 1/b/b0",
                     valid_e0, rd1_e0, pc_e0);
        end
        tick();
        checks++;
        if (valid_e0 !== 1'b0) begin
            errors++;
            $display("FAIL noskid_drain got v=%0b want 0", valid_e0);
        end
        ready_e0 = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            valid    = 1'($urandom_range(0, 1));
            ready_e  = 1'($urandom_range(0, 1));
            clr      = ($urandom_range(0, 31) == 0);
            valid0   = 1'($urandom_range(0, 1));
            ready_e0 = 1'($urandom_range(0, 1));
            clr0     = ($urandom_range(0, 31) == 0);
            rd1 = $urandom; rd2 = $urandom; imm = $urandom;
            pc = $urandom; pc4 = $urandom;
            rd = 5'($urandom); ctrl = 9'($urandom);
            tick();
        end
        valid = 1'b0; clr = 1'b0; ready_e = 1'b1;
        valid0 = 1'b0; clr0 = 1'b0; ready_e0 = 1'b1;
        repeat (4) tick();
        checks++;
        if (valid_e !== 1'b0 || valid_e0 !== 1'b0 || q.size() != 0
            || q0.size() != 0) begin
            errors++;
            $display("FAIL random_drain got v=%0b v0=%0b q=%0d q0=%0d want 0",
                     valid_e, valid_e0, q.size(), q0.size());
        end
        ready_e = 1'b0; ready_e0 = 1'b0;
    endtask

    task automatic test_reset_full();
        ready_e = 1'b0;
        valid = 1'b1; rd1 = 32'hD; ctrl = 9'h1FF;
        tick();
        rd1 = 32'hE;
        tick();
        valid = 1'b0;
        checks++;
        if (count_e !== 2'd2) begin
            errors++;
            $display("FAIL rstfull_fill got c=%0d want 2", count_e);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (count_e !== 2'd0 || ready_d !== 1'b1 || valid_e !== 1'b0
            || out_pl !== '0) begin
            errors++;
            $display("FAIL rstfull got c=%0d r=%0b v=%0b pl=%h want 0/1/0/0",
                     count_e, ready_d, valid_e, out_pl);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skid();
        test_flush();
        test_noskid();
        test_random();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
